// File: rtl/adc_poly_corrector_param.sv
// ADC linearity corrector: per-section normalisation followed by a Horner-rule polynomial
// evaluated on one shared fixed-point multiplier, with coefficients loaded over a write port.
module adc_poly_corrector_param #(
    parameter int IN_W   = 21,
    parameter int COEF_W = 32,
    parameter int FRAC   = 10,
    parameter int ORDER  = 10,
    parameter int ADDR_W = 6
) (
    input  logic              sys_clk_i,
    input  logic              reset_i,
    input  logic [IN_W-1:0]   adc_in_i,
    input  logic              srdyi,
    output logic              in_rdy_o,
    input  logic              bypass_i,
    input  logic [IN_W-2:0]   section_limit,
    input  logic              cfg_we_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [COEF_W-1:0] cfg_data_i,
    output logic              cfg_err_o,
    output logic [IN_W-1:0]   adc_out_o,
    output logic              srdyo,
    output logic              ovf_o,
    output logic [2:0]        dbg_state
);

    localparam int N_COEF  = ORDER + 1;
    localparam int M_BASE  = 4 * N_COEF;
    localparam int N_WORDS = M_BASE + 8;
    localparam int IDX_W   = $clog2(N_WORDS);
    localparam int K_W     = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int WW      = 2 * COEF_W + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SUB  = 3'd1,
        S_MUL  = 3'd2,
        S_HORN = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // Handshake: a sample transfers on a rising edge where srdyi and in_rdy_o are both high;
    // in_rdy_o is high only in IDLE, and a srdyi seen while busy is dropped, never queued.
    // srdyo is a one-cycle pulse; adc_out_o/ovf_o hold their value until the next result.

    state_t                   state;
    logic signed [COEF_W-1:0] mem [N_WORDS];
    logic signed [IN_W-1:0]   x_r;
    logic [1:0]               sec_r;
    logic                     byp_r;
    logic signed [COEF_W-1:0] d_r;
    logic signed [COEF_W-1:0] u_r;
    logic signed [COEF_W-1:0] acc_r;
    logic [K_W-1:0]           k_r;
    logic                     sticky_r;

    logic [IN_W-1:0]          mag;
    logic                     big;
    logic                     nonpos;
    logic [1:0]               sec_in;
    logic [IDX_W-1:0]         coef_k;
    logic [IDX_W-1:0]         coef_idx;
    logic [IDX_W-1:0]         mean_idx;
    logic [IDX_W-1:0]         istd_idx;
    logic signed [COEF_W-1:0] coef_v;
    logic signed [COEF_W-1:0] mean_v;
    logic signed [COEF_W-1:0] istd_v;
    logic signed [COEF_W-1:0] mac_a;
    logic signed [COEF_W-1:0] mac_b;
    logic signed [2*COEF_W-1:0] prod;
    logic signed [WW-1:0]     prod_w;
    logic signed [WW-1:0]     sub_w;
    logic signed [WW-1:0]     mul_w;
    logic signed [WW-1:0]     horn_w;
    logic signed [WW-1:0]     out_w;
    logic [COEF_W:0]          sub_s;
    logic [COEF_W:0]          mul_s;
    logic [COEF_W:0]          horn_s;
    logic [IN_W:0]            out_s;
    logic                     addr_ok;

    function automatic logic signed [WW-1:0] sext_c(input logic signed [COEF_W-1:0] v);
        sext_c = $signed({{(WW-COEF_W){v[COEF_W-1]}}, v});
    endfunction

    // Saturating narrowers return {clamped_flag, value}.
    function automatic logic [COEF_W:0] sat_c(input logic signed [WW-1:0] v);
        logic signed [WW-1:0] hi;
        logic signed [WW-1:0] lo;
        hi = $signed({{(WW-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}});
        lo = ~hi;
        if (v > hi)      sat_c = {1'b1, hi[COEF_W-1:0]};
        else if (v < lo) sat_c = {1'b1, lo[COEF_W-1:0]};
        else             sat_c = {1'b0, v[COEF_W-1:0]};
    endfunction

    function automatic logic [IN_W:0] sat_i(input logic signed [WW-1:0] v);
        logic signed [WW-1:0] hi;
        logic signed [WW-1:0] lo;
        hi = $signed({{(WW-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}});
        lo = ~hi;
        if (v > hi)      sat_i = {1'b1, hi[IN_W-1:0]};
        else if (v < lo) sat_i = {1'b1, lo[IN_W-1:0]};
        else             sat_i = {1'b0, v[IN_W-1:0]};
    endfunction

    // Identity table: c[s][1]=1.0, istd=1.0, everything else zero.
    function automatic logic signed [COEF_W-1:0] reset_word(input int i);
        logic signed [COEF_W-1:0] one;
        one = COEF_W'(1) <<< FRAC;
        if ((i < M_BASE && (i % N_COEF) == 1) || i >= M_BASE + 4) reset_word = one;
        else                                                       reset_word = '0;
    endfunction

    always_comb begin
        mag      = adc_in_i[IN_W-1] ? (~adc_in_i + 1'b1) : adc_in_i;
        big      = mag > {1'b0, section_limit};
        nonpos   = adc_in_i[IN_W-1] | (adc_in_i == '0);
        sec_in   = nonpos ? (big ? 2'd0 : 2'd1) : (big ? 2'd3 : 2'd2);

        coef_k   = (state == S_MUL) ? IDX_W'(ORDER) : IDX_W'(k_r);
        coef_idx = IDX_W'(sec_r) * IDX_W'(N_COEF) + coef_k;
        mean_idx = IDX_W'(M_BASE) + IDX_W'(sec_r);
        istd_idx = IDX_W'(M_BASE + 4) + IDX_W'(sec_r);
        coef_v   = mem[coef_idx];
        mean_v   = mem[mean_idx];
        istd_v   = mem[istd_idx];

        // One multiplier serves both the normalising scale and every Horner step.
        mac_a    = (state == S_MUL) ? d_r : acc_r;
        mac_b    = (state == S_MUL) ? istd_v : u_r;
        prod     = $signed({{COEF_W{mac_a[COEF_W-1]}}, mac_a}) *
                   $signed({{COEF_W{mac_b[COEF_W-1]}}, mac_b});
        prod_w   = $signed({{2{prod[2*COEF_W-1]}}, prod});

        sub_w    = ($signed({{(WW-IN_W){x_r[IN_W-1]}}, x_r}) <<< FRAC) - sext_c(mean_v);
        mul_w    = prod_w >>> FRAC;
        horn_w   = (prod_w >>> FRAC) + sext_c(coef_v);
        out_w    = (sext_c(acc_r) + WW'(1 << (FRAC - 1))) >>> FRAC;

        sub_s    = sat_c(sub_w);
        mul_s    = sat_c(mul_w);
        horn_s   = sat_c(horn_w);
        out_s    = sat_i(out_w);

        addr_ok  = {1'b0, cfg_addr_i} < (ADDR_W + 1)'(N_WORDS);
    end

    assign in_rdy_o  = (state == S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= S_IDLE;
            x_r       <= '0;
            sec_r     <= '0;
            byp_r     <= 1'b0;
            d_r       <= '0;
            u_r       <= '0;
            acc_r     <= '0;
            k_r       <= '0;
            sticky_r  <= 1'b0;
            adc_out_o <= '0;
            srdyo     <= 1'b0;
            ovf_o     <= 1'b0;
            cfg_err_o <= 1'b0;
            for (int i = 0; i < N_WORDS; i++) mem[i] <= reset_word(i);
        end else begin
            srdyo     <= 1'b0;
            cfg_err_o <= 1'b0;

            // Tables are read from SUB to HORN, so writes are only taken in IDLE.
            if (cfg_we_i) begin
                if (state == S_IDLE && addr_ok) mem[IDX_W'(cfg_addr_i)] <= $signed(cfg_data_i);
                else                            cfg_err_o <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (srdyi) begin
                        x_r      <= $signed(adc_in_i);
                        sec_r    <= sec_in;
                        byp_r    <= bypass_i;
                        sticky_r <= 1'b0;
                        state    <= S_SUB;
                    end
                end
                S_SUB: begin
                    d_r      <= $signed(sub_s[COEF_W-1:0]);
                    sticky_r <= sticky_r | sub_s[COEF_W];
                    state    <= S_MUL;
                end
                S_MUL: begin
                    u_r      <= $signed(mul_s[COEF_W-1:0]);
                    sticky_r <= sticky_r | mul_s[COEF_W];
                    acc_r    <= coef_v;
                    k_r      <= K_W'(ORDER - 1);
                    state    <= S_HORN;
                end
                S_HORN: begin
                    acc_r    <= $signed(horn_s[COEF_W-1:0]);
                    sticky_r <= sticky_r | horn_s[COEF_W];
                    if (k_r == '0) state <= S_OUT;
                    else           k_r   <= k_r - 1'b1;
                end
                S_OUT: begin
                    srdyo <= 1'b1;
                    if (byp_r) begin
                        adc_out_o <= x_r;
                        ovf_o     <= 1'b0;
                    end else begin
                        adc_out_o <= out_s[IN_W-1:0];
                        ovf_o     <= sticky_r | out_s[IN_W];
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_poly_corrector_param.sv
// Self-checking bench for adc_poly_corrector_param: directed steps plus randomized traffic
// compared against a plain-arithmetic reference model of the corrector.
module tb_adc_poly_corrector_param;

    localparam int IN_W    = 21;
    localparam int COEF_W  = 32;
    localparam int FRAC    = 10;
    localparam int ORDER   = 10;
    localparam int ADDR_W  = 6;
    localparam int N_COEF  = ORDER + 1;
    localparam int M_BASE  = 4 * N_COEF;
    localparam int N_WORDS = M_BASE + 8;
    localparam int LAT     = ORDER + 3;
    localparam longint CMAX = 64'sd2147483647;
    localparam longint CMIN = -64'sd2147483648;
    localparam longint OMAX = 64'sd1048575;
    localparam longint OMIN = -64'sd1048576;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IN_W-1:0]   adc_in = '0;
    logic              srdyi = 1'b0;
    logic              in_rdy;
    logic              bypass = 1'b0;
    logic [IN_W-2:0]   limit = '0;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [COEF_W-1:0] cfg_data = '0;
    logic              cfg_err;
    logic [IN_W-1:0]   adc_out;
    logic              srdyo;
    logic              ovf;
    logic [2:0]        dbg_state;

    adc_poly_corrector_param #(
        .IN_W(IN_W), .COEF_W(COEF_W), .FRAC(FRAC), .ORDER(ORDER), .ADDR_W(ADDR_W)
    ) dut (
        .sys_clk_i    (clk),
        .reset_i      (rst_n),
        .adc_in_i     (adc_in),
        .srdyi        (srdyi),
        .in_rdy_o     (in_rdy),
        .bypass_i     (bypass),
        .section_limit(limit),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .cfg_err_o    (cfg_err),
        .adc_out_o    (adc_out),
        .srdyo        (srdyo),
        .ovf_o        (ovf),
        .dbg_state    (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int e0_cyc  = 0;
    logic [IN_W:0] exp_q[$];

    // reference model
    longint m_coef [4][N_COEF];
    longint m_mean [4];
    longint m_istd [4];
    bit     m_ov;

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < N_COEF; k++) m_coef[s][k] = (k == 1) ? 1024 : 0;
            m_mean[s] = 0;
            m_istd[s] = 1024;
        end
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) begin m_ov = 1'b1; return hi; end
        if (v < lo) begin m_ov = 1'b1; return lo; end
        return v;
    endfunction

    function automatic logic [IN_W:0] model(input longint x, input longint lim, input bit byp);
        int s;
        longint mag, d, u, acc, y;
        mag = (x < 0) ? -x : x;
        if (x <= 0) s = (mag > lim) ? 0 : 1;
        else        s = (mag > lim) ? 3 : 2;
        if (byp) begin
            y = x;
            return {1'b0, y[IN_W-1:0]};
        end
        m_ov = 1'b0;
        d   = clamp(x * 1024 - m_mean[s], CMIN, CMAX);
        u   = clamp((d * m_istd[s]) >>> FRAC, CMIN, CMAX);
        acc = m_coef[s][ORDER];
        for (int k = ORDER - 1; k >= 0; k--)
            acc = clamp(((acc * u) >>> FRAC) + m_coef[s][k], CMIN, CMAX);
        y = clamp((acc + 512) >>> FRAC, OMIN, OMAX);
        return {m_ov, y[IN_W-1:0]};
    endfunction

    // scoreboard comparison
    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic start_sample(input logic signed [IN_W-1:0] x, input bit byp,
                                input logic [IN_W-2:0] lim);
        int n;
        n = 0;
        @(negedge clk);
        while (in_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", in_rdy, 1);
        adc_in = x;
        bypass = byp;
        limit  = lim;
        srdyi  = 1'b1;
        exp_q.push_back(model(longint'(x), longint'(lim), byp));
        @(posedge clk);
        #1;
        e0_cyc = cyc;
        srdyi  = 1'b0;
    endtask

    task automatic finish_sample(input string tag);
        int n;
        logic [IN_W:0] e;
        n = 0;
        while (srdyo !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, cyc - e0_cyc, LAT);
        e = exp_q.pop_front();
        check({tag, "_ovf_out"}, {ovf, adc_out}, e);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, srdyo, 0);
    endtask

    task automatic cfg_write(input int addr, input logic signed [COEF_W-1:0] data, input bit busy);
        bit exp_err;
        exp_err = busy || (addr >= N_WORDS);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check("cfg_err", cfg_err, exp_err);
        if (!exp_err) begin
            if (addr < M_BASE)          m_coef[addr / N_COEF][addr % N_COEF] = longint'(data);
            else if (addr < M_BASE + 4) m_mean[addr - M_BASE] = longint'(data);
            else                        m_istd[addr - M_BASE - 4] = longint'(data);
        end
    endtask

    task automatic count_pulses(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (srdyo === 1'b1) cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int op;
        int a;
        logic signed [IN_W-1:0] rx;
        logic signed [COEF_W-1:0] rd;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out", adc_out, 0);
        check("rst_srdyo", srdyo, 0);
        check("rst_ovf", ovf, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        // identity transfer
        start_sample(100, 0, 1000);
        finish_sample("t1_pos");
        check("t1_pos_val", $signed(adc_out), 100);
        check("t1_pos_ovf", ovf, 0);
        start_sample(-1048576, 0, 1000);
        finish_sample("t1_neg");
        check("t1_neg_val", $signed(adc_out), -1048576);

        // loaded section 3 polynomial, section 2 stays identity
        cfg_write(3 * N_COEF + 0, 5 << 10, 0);
        cfg_write(3 * N_COEF + 1, 2 << 10, 0);
        start_sample(2000, 0, 1000);
        finish_sample("t2_poly");
        check("t2_poly_val", $signed(adc_out), 4005);
        start_sample(500, 0, 1000);
        finish_sample("t2_ident");
        check("t2_ident_val", $signed(adc_out), 500);

        // normalisation of section 2
        cfg_write(M_BASE + 2, 10 << 10, 0);
        cfg_write(M_BASE + 4 + 2, 1 << 9, 0);
        start_sample(30, 0, 1000);
        finish_sample("t3_norm");
        check("t3_norm_val", $signed(adc_out), 10);

        // saturation
        cfg_write(3 * N_COEF + 2, 1 << 10, 0);
        start_sample(1048575, 0, 0);
        finish_sample("t4_sat");
        check("t4_sat_val", $signed(adc_out), 1048575);
        check("t4_sat_ovf", ovf, 1);

        // write while busy is rejected and does not disturb the running sample
        start_sample(20, 0, 1000);
        repeat (4) @(posedge clk);
        cfg_write(3 * N_COEF + 0, 32'sd777, 1);
        finish_sample("t5_busywr");
        start_sample(25, 0, 1000);
        finish_sample("t5_unchanged");
        cfg_write(N_WORDS, 32'sd123, 0);
        cfg_write(63, 32'sd55, 0);

        // srdyi while busy is dropped
        start_sample(40, 0, 1000);
        @(negedge clk);
        adc_in = 21'sd7;
        srdyi  = 1'b1;
        repeat (4) @(negedge clk);
        srdyi  = 1'b0;
        finish_sample("t5_drop");
        count_pulses(20, cnt);
        check("t5_extra_pulses", cnt, 0);

        // reset mid-operation abandons the sample and restores identity
        start_sample(2000, 0, 1000);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("t6_rst_in_rdy", in_rdy, 1);
        check("t6_rst_srdyo", srdyo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_pulses(20, cnt);
        check("t6_no_pulse", cnt, 0);
        start_sample(2000, 0, 1000);
        finish_sample("t6_ident");
        check("t6_ident_val", $signed(adc_out), 2000);
        start_sample(-7, 1, 1000);
        finish_sample("t6_bypass");
        check("t6_bypass_val", $signed(adc_out), -7);
        check("t6_bypass_ovf", ovf, 0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            if (op < 2) begin
                a  = int'($urandom_range(0, 3)) * N_COEF + int'($urandom_range(0, 2));
                rd = COEF_W'(int'($urandom_range(0, 4096)) - 2048);
                cfg_write(a, rd, 0);
            end else if (op == 2) begin
                a = M_BASE + int'($urandom_range(0, 7));
                if (a < M_BASE + 4) rd = COEF_W'(int'($urandom_range(0, 200000)) - 100000);
                else                rd = COEF_W'(int'($urandom_range(256, 2048)));
                cfg_write(a, rd, 0);
            end else if (op == 3) begin
                cfg_write(int'($urandom_range(N_WORDS, 63)), COEF_W'($urandom), 0);
            end else begin
                if ($urandom_range(0, 1) == 1) rx = IN_W'(int'($urandom_range(0, 4000)) - 2000);
                else                           rx = IN_W'($urandom);
                start_sample(rx, ($urandom_range(0, 7) == 0), (IN_W-1)'($urandom_range(0, 3000)));
                finish_sample("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
